comm_pkt_tx: RTL and testbench
==============================

COMM_PKT_TX -- requirements
Module: comm_pkt_tx

Interface
REQ-001 Parameter MAX_PAYLOAD, default 52, maximum payload bytes per packet (60-byte message buffer minus 8 bytes of header and CRC).
REQ-002 comm_clk  input  1  sole clock; 16x UART baud domain.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  caller presents a packet request.
REQ-005 req_ready  output  1  block idle; a request is accepted when req_valid & req_ready are high on the same edge.
REQ-006 req_type  input  8  message type byte (INFO=0, INVALID=1, ACK=2, RESEND=3, PUSH_JOB=4, QUEUE_JOB=5, NONCE_FOUND=6).
REQ-007 req_len  input  8  payload byte count, 0..MAX_PAYLOAD.
REQ-008 req_payload  input  MAX_PAYLOAD*8  payload; byte 0 in [7:0], sent first.
REQ-009 tx_busy  input  1  downstream UART TX FIFO cannot take a byte this cycle.
REQ-010 tx_we  output  1  one-cycle byte write strobe to the UART TX FIFO.
REQ-011 tx_data  output  8  byte qualified by tx_we.
REQ-012 err_len  output  1  one-cycle pulse: request rejected, req_len > MAX_PAYLOAD.
REQ-013 pkt_done  output  1  one-cycle pulse, coincident with the last CRC byte's tx_we.

Function
REQ-014 Packet byte order: LEN, 0x00, 0x00, TYPE, payload[0..req_len-1], CRC[7:0], CRC[15:8], CRC[23:16], CRC[31:24].
REQ-015 LEN = req_len + 8; LEN is 8-bit and cannot overflow because MAX_PAYLOAD <= 247.
REQ-016 On acceptance: latch type, length and payload; clear req_ready; initialise CRC to 0xFFFFFFFF.
REQ-017 CRC: CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, no final XOR, computed over every byte from LEN through the last payload byte; the appended register value gives a zero residual at the receiver.
REQ-018 FSM states: IDLE -> HDR (4 bytes) -> PAY (req_len bytes, skipped when 0) -> CRC (4 bytes) -> IDLE.
REQ-019 A byte is emitted (tx_we=1) in any non-IDLE cycle where tx_busy=0; when tx_busy=1, tx_we=0 and the byte index, CRC and tx_data are held.
REQ-020 Latency: the first tx_we occurs on the cycle after acceptance if tx_busy=0; the packet takes exactly LEN tx_we pulses.
REQ-021 pkt_done and the return to IDLE occur on the cycle of the final CRC byte; req_ready=1 on the following cycle; there is no dead cycle beyond that.
REQ-022 Payload is shifted out from a latched copy; changes to req_* after acceptance have no effect.
REQ-023 req_len > MAX_PAYLOAD: the request is accepted (one-cycle handshake), err_len pulses, no bytes are emitted, and req_ready stays 1.
REQ-024 The CRC used for the trailer includes the last payload byte even if tx_busy stalls between the payload and the CRC bytes.
REQ-025 req_valid held high across pkt_done: the next packet is accepted on the cycle req_ready rises.

Reset
REQ-026 While reset_n=0 on an edge: state=IDLE, req_ready=1, tx_we=0, tx_data=0x00, err_len=0, pkt_done=0, CRC=0xFFFFFFFF.
REQ-027 Reset mid-packet aborts immediately; the partial packet is not completed; no tx_we is issued in the reset cycle.
REQ-028 A request presented while reset_n=0 is not accepted.

Structure
REQ-029 Message type codes, header length (4), CRC length (4) and MAX_PAYLOAD default live in the shared comm package, used by both comm_pkt_tx and the receiver.
REQ-030 The per-byte CRC update is one sub-module, crc32_byte (combinational next-CRC from current CRC and byte); the block owns the CRC register.
REQ-031 The block has no FIFO of its own; it relies on tx_busy from the existing UART TX FIFO.

Verification
REQ-032 ACK, req_len=0, tx_busy=0 -> 8 consecutive tx_we: 08 00 00 02 followed by 4 CRC bytes matching the software model; the receiver-side CRC over all 8 bytes = 0; pkt_done on the 8th byte.
REQ-033 INFO, req_len=8, payload 13 0D 37 13 EF BE AD DE -> LEN=0x10, 16 bytes, payload in the listed order, CRC matches the model.
REQ-034 NONCE_FOUND, 4-byte payload, tx_busy toggled on a random 50% pattern -> same byte sequence as the unstalled run, exactly 12 tx_we, no byte duplicated or dropped.
REQ-035 req_len=53 -> err_len pulse one cycle after acceptance, zero tx_we, req_ready=1 throughout.
REQ-036 reset_n=0 for one cycle after the 6th byte of a 20-byte packet -> tx_we=0 from that cycle on, req_ready=1; the next ACK request produces a correct 8-byte packet.
REQ-037 Back-to-back: req_valid held with two requests -> second packet's LEN byte appears on the cycle after pkt_done+1 (no idle gap beyond REQ-021).

Source files
------------

// File: rtl/comm_pkg.sv
// Shared comm definitions used by the packet transmitter and the receiver:
// message type codes, framing lengths, CRC-32 constants and the TX FSM state type.
package comm_pkg;

   localparam int unsigned MAX_PAYLOAD_DEF = 52;  // 60-byte buffer minus header and CRC
   localparam int unsigned HDR_LEN         = 4;
   localparam int unsigned CRC_LEN         = 4;

   localparam logic [7:0] MSG_INFO        = 8'd0;
   localparam logic [7:0] MSG_INVALID     = 8'd1;
   localparam logic [7:0] MSG_ACK         = 8'd2;
   localparam logic [7:0] MSG_RESEND      = 8'd3;
   localparam logic [7:0] MSG_PUSH_JOB    = 8'd4;
   localparam logic [7:0] MSG_QUEUE_JOB   = 8'd5;
   localparam logic [7:0] MSG_NONCE_FOUND = 8'd6;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;  // reflected
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {StIdle, StHdr, StPay, StCrc} tx_state_e;

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 (reflected) update for one byte, LSB first.
// Ports: crc      - current CRC register value
//        data     - byte to fold in
//        crc_next - CRC after the byte
module crc32_byte
   import comm_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   always_comb begin
      crc_next = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY) : (crc_next >> 1);
      end
   end

endmodule

// File: rtl/comm_pkt_tx.sv
// Packet transmitter: frames a request as LEN, 0, 0, TYPE, payload, CRC-32 (LSB first)
// and writes it byte by byte into the UART TX FIFO, honouring tx_busy back-pressure.
// Ports: comm_clk/reset_n  - clock, synchronous active-low reset
//        req_*             - request handshake, type, length and payload (byte 0 in [7:0])
//        tx_busy           - FIFO cannot take a byte this cycle
//        tx_we/tx_data     - byte write strobe and data to the FIFO
//        err_len           - pulse: request rejected for oversize length
//        pkt_done          - pulse with the last CRC byte's write strobe
module comm_pkt_tx
   import comm_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
   input  logic                     comm_clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [7:0]               req_type,
   input  logic [7:0]               req_len,
   input  logic [MAX_PAYLOAD*8-1:0] req_payload,
   input  logic                     tx_busy,
   output logic                     tx_we,
   output logic [7:0]               tx_data,
   output logic                     err_len,
   output logic                     pkt_done
);

   localparam logic [7:0] MaxLen  = 8'(MAX_PAYLOAD);
   localparam logic [7:0] HdrLast = 8'(HDR_LEN - 1);
   localparam logic [7:0] CrcLast = 8'(CRC_LEN - 1);

   tx_state_e                state_q, state_d;
   logic [7:0]               idx_q, idx_d;
   logic [31:0]              crc_q, crc_d, crc_nxt;
   logic [7:0]               type_q, type_d;
   logic [7:0]               len_q, len_d;
   logic [MAX_PAYLOAD*8-1:0] pay_q, pay_d;
   logic                     err_q, err_d;

   crc32_byte u_crc (
      .crc      (crc_q),
      .data     (tx_data),
      .crc_next (crc_nxt)
   );

   // Byte emission; gating with reset_n keeps a reset cycle from writing a stray byte.
   always_comb begin
      req_ready = (state_q == StIdle);
      tx_we     = (state_q != StIdle) && !tx_busy && reset_n;
      tx_data   = 8'h00;
      unique case (state_q)
         StIdle: tx_data = 8'h00;
         StHdr: begin
            case (idx_q[1:0])
               2'd0:    tx_data = len_q + 8'd8;
               2'd3:    tx_data = type_q;
               default: tx_data = 8'h00;
            endcase
         end
         StPay: tx_data = pay_q[7:0];
         StCrc: tx_data = crc_q[{idx_q[1:0], 3'b000} +: 8];
      endcase
      pkt_done = tx_we && (state_q == StCrc) && (idx_q == CrcLast);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      crc_d   = crc_q;
      type_d  = type_q;
      len_d   = len_q;
      pay_d   = pay_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_len > MaxLen) begin
                  err_d = 1'b1;  // handshake completes, nothing is sent
               end else begin
                  state_d = StHdr;
                  idx_d   = 8'd0;
                  crc_d   = CRC32_INIT;
                  type_d  = req_type;
                  len_d   = req_len;
                  pay_d   = req_payload;
               end
            end
         end
         StHdr: begin
            if (tx_we) begin
               crc_d = crc_nxt;
               if (idx_q == HdrLast) begin
                  idx_d   = 8'd0;
                  state_d = (len_q == 8'd0) ? StCrc : StPay;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         StPay: begin
            if (tx_we) begin
               crc_d = crc_nxt;
               pay_d = pay_q >> 8;
               if (idx_q == len_q - 8'd1) begin
                  idx_d   = 8'd0;
                  state_d = StCrc;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         StCrc: begin
            // CRC register is frozen here; its bytes are the trailer.
            if (tx_we) begin
               if (idx_q == CrcLast) begin
                  idx_d   = 8'd0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge comm_clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= 8'd0;
         crc_q   <= CRC32_INIT;
         type_q  <= 8'd0;
         len_q   <= 8'd0;
         pay_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         crc_q   <= crc_d;
         type_q  <= type_d;
         len_q   <= len_d;
         pay_q   <= pay_d;
         err_q   <= err_d;
      end
   end

   assign err_len = err_q;

endmodule

// File: tb/tb_comm_pkt_tx.sv
// Directed self-checking bench for comm_pkt_tx.
module tb_comm_pkt_tx;
   import comm_pkg::*;

   localparam int unsigned MP = 52;

   logic            comm_clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [7:0]      req_type = 8'd0;
   logic [7:0]      req_len = 8'd0;
   logic [MP*8-1:0] req_payload = '0;
   logic            tx_busy = 1'b0;
   logic            tx_we;
   logic [7:0]      tx_data;
   logic            err_len;
   logic            pkt_done;

   int errors = 0;
   int checks = 0;
   int ncyc = 0;
   int rdy_low = 0;
   int stray_done = 0;
   logic [7:0] byte_q[$];
   int         bcyc_q[$];
   int         done_q[$];
   int         acc_q[$];
   int         err_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] tmp_q[$];
   logic [MP*8-1:0] pay;

   always #5 comm_clk = ~comm_clk;

   comm_pkt_tx #(.MAX_PAYLOAD(MP)) dut (
      .comm_clk    (comm_clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_type    (req_type),
      .req_len     (req_len),
      .req_payload (req_payload),
      .tx_busy     (tx_busy),
      .tx_we       (tx_we),
      .tx_data     (tx_data),
      .err_len     (err_len),
      .pkt_done    (pkt_done)
   );

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge comm_clk) begin
      ncyc++;
      if (reset_n) begin
         if (req_valid && req_ready) acc_q.push_back(ncyc);
         if (!req_ready) rdy_low++;
      end
      if (tx_we) begin
         byte_q.push_back(tx_data);
         bcyc_q.push_back(ncyc);
         if (pkt_done) done_q.push_back(byte_q.size() - 1);
      end else if (pkt_done) begin
         stray_done++;
      end
      if (err_len) err_q.push_back(ncyc);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // Bit-serial reference CRC over a byte stream.
   function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      logic fb;
      foreach (d[k]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[k][b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_exp(input logic [7:0] typ, input int len, input logic [MP*8-1:0] pl);
      logic [31:0] c;
      exp_q.delete();
      exp_q.push_back(8'(len + 8));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(typ);
      for (int i = 0; i < len; i++) exp_q.push_back(pl[i*8 +: 8]);
      c = crc_model(exp_q);
      for (int i = 0; i < 4; i++) exp_q.push_back(c[i*8 +: 8]);
   endtask

   task automatic clear_mon();
      byte_q.delete();
      bcyc_q.delete();
      done_q.delete();
      acc_q.delete();
      err_q.delete();
      rdy_low = 0;
   endtask

   // Present a request; returns one cycle into the cycle after acceptance.
   task automatic send(input string tag, input logic [7:0] typ, input logic [7:0] len,
                       input logic [MP*8-1:0] pl);
      logic got = 1'b0;
      req_valid   = 1'b1;
      req_type    = typ;
      req_len     = len;
      req_payload = pl;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge comm_clk);
         if (req_ready) got = 1'b1;
      end
      check({tag, " accepted"}, 64'(got), 64'd1);
      @(posedge comm_clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && done_q.size() < n; k++) begin
         @(posedge comm_clk);
         #1;
      end
      repeat (2) @(posedge comm_clk);
      #1;
      check({tag, " completed"}, 64'(done_q.size() >= n), 64'd1);
   endtask

   task automatic cmp_pkt(input string tag);
      check({tag, " byte count"}, 64'(byte_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < byte_q.size())
            check($sformatf("%s byte%0d", tag, i), 64'(byte_q[i]), 64'(exp_q[i]));
      end
      check({tag, " residual"}, 64'(crc_model(byte_q)), 64'd0);
      check({tag, " done count"}, 64'(done_q.size()), 64'd1);
      if (done_q.size() == 1)
         check({tag, " done position"}, 64'(done_q[0]), 64'(exp_q.size() - 1));
   endtask

   initial begin
      // Reset with a request pending: outputs at reset values, nothing accepted.
      req_valid = 1'b1;
      req_type  = MSG_ACK;
      repeat (3) @(posedge comm_clk);
      #1;
      check("rst req_ready", 64'(req_ready), 64'd1);
      check("rst tx_we", 64'(tx_we), 64'd0);
      check("rst tx_data", 64'(tx_data), 64'd0);
      check("rst err_len", 64'(err_len), 64'd0);
      check("rst pkt_done", 64'(pkt_done), 64'd0);
      req_valid = 1'b0;
      reset_n   = 1'b1;
      repeat (4) @(posedge comm_clk);
      #1;
      check("rst no bytes", 64'(byte_q.size()), 64'd0);

      // ACK, zero payload, no back-pressure: 8 consecutive bytes.
      clear_mon();
      build_exp(MSG_ACK, 0, '0);
      check("ack crc model b0", 64'(exp_q[0]), 64'h08);
      send("ack", MSG_ACK, 8'd0, '0);
      wait_done("ack", 1, 50);
      cmp_pkt("ack");
      if (acc_q.size() == 1 && bcyc_q.size() == 8) begin
         check("ack first latency", 64'(bcyc_q[0]), 64'(acc_q[0] + 1));
         check("ack contiguous", 64'(bcyc_q[7] - bcyc_q[0]), 64'd7);
      end
      check("ack stray done", 64'(stray_done), 64'd0);

      // INFO with 8-byte payload; inputs scrambled after acceptance.
      clear_mon();
      pay = '0;
      pay[63:0] = 64'hDEADBEEF_13370D13;
      build_exp(MSG_INFO, 8, pay);
      send("info", MSG_INFO, 8'd8, pay);
      req_payload = '1;
      req_len     = 8'd3;
      req_type    = MSG_QUEUE_JOB;
      wait_done("info", 1, 60);
      cmp_pkt("info");

      // NONCE_FOUND with random 50% back-pressure.
      clear_mon();
      pay = '0;
      pay[31:0] = 32'hA55AC33C;
      build_exp(MSG_NONCE_FOUND, 4, pay);
      send("nonce", MSG_NONCE_FOUND, 8'd4, pay);
      for (int k = 0; k < 300 && done_q.size() < 1; k++) begin
         tx_busy = 1'($urandom_range(0, 1));
         @(posedge comm_clk);
         #1;
      end
      tx_busy = 1'b0;
      wait_done("nonce", 1, 10);
      cmp_pkt("nonce");

      // Same packet, stalled exactly between last payload byte and first CRC byte.
      clear_mon();
      send("stall", MSG_NONCE_FOUND, 8'd4, pay);
      for (int k = 0; k < 60 && done_q.size() < 1; k++) begin
         tx_busy = (k >= 8 && k < 11);
         @(posedge comm_clk);
         #1;
      end
      tx_busy = 1'b0;
      wait_done("stall", 1, 10);
      cmp_pkt("stall");
      if (bcyc_q.size() == 12) check("stall gap", 64'(bcyc_q[8] - bcyc_q[7]), 64'd4);

      // Oversize length: err pulse, no bytes, ready never drops.
      clear_mon();
      send("oversize", MSG_INFO, 8'd53, '1);
      repeat (5) @(posedge comm_clk);
      #1;
      check("oversize err count", 64'(err_q.size()), 64'd1);
      if (err_q.size() == 1 && acc_q.size() == 1)
         check("oversize err timing", 64'(err_q[0]), 64'(acc_q[0] + 1));
      check("oversize bytes", 64'(byte_q.size()), 64'd0);
      check("oversize ready low", 64'(rdy_low), 64'd0);

      // Reset after the 6th byte of a 20-byte packet.
      clear_mon();
      pay = '0;
      for (int i = 0; i < 12; i++) pay[i*8 +: 8] = 8'(8'h40 + i);
      send("abort", MSG_PUSH_JOB, 8'd12, pay);
      repeat (6) @(posedge comm_clk);
      #1;
      reset_n = 1'b0;
      @(posedge comm_clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(posedge comm_clk);
      #1;
      check("abort bytes", 64'(byte_q.size()), 64'd6);
      check("abort ready", 64'(req_ready), 64'd1);
      check("abort no done", 64'(done_q.size()), 64'd0);
      clear_mon();
      build_exp(MSG_ACK, 0, '0);
      send("postrst", MSG_ACK, 8'd0, '0);
      wait_done("postrst", 1, 50);
      cmp_pkt("postrst");

      // Back-to-back with req_valid held high across pkt_done.
      clear_mon();
      build_exp(MSG_INFO, 2, 416'h7E81);
      tmp_q = exp_q;
      build_exp(MSG_ACK, 0, '0);
      exp_q = {exp_q, tmp_q};
      req_valid   = 1'b1;
      req_type    = MSG_ACK;
      req_len     = 8'd0;
      req_payload = '0;
      for (int k = 0; k < 20 && acc_q.size() < 1; k++) begin
         @(posedge comm_clk);
         #1;
      end
      req_type    = MSG_INFO;
      req_len     = 8'd2;
      req_payload = 416'h7E81;
      for (int k = 0; k < 50 && acc_q.size() < 2; k++) begin
         @(posedge comm_clk);
         #1;
      end
      req_valid = 1'b0;
      wait_done("b2b", 2, 60);
      check("b2b byte count", 64'(byte_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < byte_q.size())
            check($sformatf("b2b byte%0d", i), 64'(byte_q[i]), 64'(exp_q[i]));
      end
      check("b2b done count", 64'(done_q.size()), 64'd2);
      if (bcyc_q.size() == 18) check("b2b gap", 64'(bcyc_q[8] - bcyc_q[7]), 64'd2);
      check("b2b stray done", 64'(stray_done), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
